// File: rtl/alu_compare_unit_if.sv
// Request/response bundle for alu_compare_unit. The master issues requests and
// consumes results; the slave is the compare unit.
interface alu_compare_unit_if #(
    parameter int WIDTH = 32
);
    // A transfer happens on a rising edge where valid && ready. A producer
    // holds valid high until that edge. A consumer may raise ready at any time.
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/alu_compare_unit.sv
// Multi-cycle MSB-first chunked comparator for SLT(U)/EQ/NE/MIN(U)/MAX(U).
// It stops at the first differing chunk. IDLE -> CMP -> DONE.
module alu_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_compare_unit_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("alu_compare_unit: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ca_q;
    logic [WIDTH-1:0] cb_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] y_q;

    logic [CHUNK-1:0] ca_chunk;
    logic [CHUNK-1:0] cb_chunk;
    logic             last_chunk;
    logic [WIDTH-1:0] sign_flip;

    // Signed compares become unsigned ones when both MSBs are flipped.
    // Only the compare copies are flipped, so min/max still return the originals.
    function automatic logic is_signed_op(input logic [2:0] o);
        return o[0] & (o[2] | ~o[1]);
    endfunction

    function automatic logic [WIDTH-1:0] result(
        input logic [2:0]       o,
        input logic             lt,
        input logic             eq,
        input logic [WIDTH-1:0] av,
        input logic [WIDTH-1:0] bv
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (o)
            3'b000, 3'b001: r[0] = lt;
            3'b010:         r[0] = eq;
            3'b011:         r[0] = ~eq;
            3'b100, 3'b101: r = lt ? av : bv;
            default:        r = lt ? bv : av;
        endcase
        return r;
    endfunction

    assign sign_flip = {is_signed_op(bus.op), {(WIDTH-1){1'b0}}};

    always_comb begin
        ca_chunk = '0;
        cb_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                ca_chunk = ca_q[(NCHUNK-1-k)*CHUNK +: CHUNK];
                cb_chunk = cb_q[(NCHUNK-1-k)*CHUNK +: CHUNK];
            end
        end
    end

    assign last_chunk = (idx_q == IW'(NCHUNK-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            idx_q <= '0;
            y_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        ca_q  <= bus.a ^ sign_flip;
                        cb_q  <= bus.b ^ sign_flip;
                        idx_q <= '0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (ca_chunk != cb_chunk) begin
                        y_q   <= result(op_q, ca_chunk < cb_chunk, 1'b0, a_q, b_q);
                        state <= DONE;
                    end else if (last_chunk) begin
                        y_q   <= result(op_q, 1'b0, 1'b1, a_q, b_q);
                        state <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    // Returning to IDLE takes one cycle. A new request is not taken here.
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_alu_compare_unit.sv
// Directed checks of alu_compare_unit at 32/8, 64/16 and 32/32.
module tb_alu_compare_unit;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [1:0] st0, st1, st2;

    alu_compare_unit_if #(.WIDTH(32)) bus0 ();
    alu_compare_unit_if #(.WIDTH(64)) bus1 ();
    alu_compare_unit_if #(.WIDTH(32)) bus2 ();

    alu_compare_unit #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(st0));
    alu_compare_unit #(.WIDTH(64), .CHUNK(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(st1));
    alu_compare_unit #(.WIDTH(32), .CHUNK(32)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(st2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_y(input int d);
        case (d)
            0:       return {32'd0, bus0.y};
            1:       return bus1.y;
            default: return {32'd0, bus2.y};
        endcase
    endfunction

    function automatic logic get_ov(input int d);
        case (d)
            0:       return bus0.out_valid;
            1:       return bus1.out_valid;
            default: return bus2.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0:       return bus0.in_ready;
            1:       return bus1.in_ready;
            default: return bus2.in_ready;
        endcase
    endfunction

    // driver tasks
    task automatic drive(input int d, input logic v, input logic [2:0] o,
                         input logic [63:0] av, input logic [63:0] bv);
        case (d)
            0: begin bus0.in_valid = v; bus0.op = o; bus0.a = av[31:0]; bus0.b = bv[31:0]; end
            1: begin bus1.in_valid = v; bus1.op = o; bus1.a = av;       bus1.b = bv;       end
            default: begin bus2.in_valid = v; bus2.op = o; bus2.a = av[31:0]; bus2.b = bv[31:0]; end
        endcase
    endtask

    task automatic set_ordy(input int d, input logic r);
        case (d)
            0:       bus0.out_ready = r;
            1:       bus1.out_ready = r;
            default: bus2.out_ready = r;
        endcase
    endtask

    task automatic scramble(input int d);
        drive(d, 1'b0, 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic accept(input int d, input logic [2:0] o,
                          input logic [63:0] av, input logic [63:0] bv);
        int n;
        n = 0;
        while (!get_ir(d) && n < 20) begin @(posedge clk); #1; n++; end
        drive(d, 1'b1, o, av, bv);
        @(posedge clk); #1;
        scramble(d);
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!get_ov(d) && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run(input int d, input logic [2:0] o, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] ey, input int elat,
                       input string tag);
        int lat;
        accept(d, o, av, bv);
        wait_done(d, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_y"}, get_y(d), ey);
        chk({tag, "_rdy_busy"}, {63'd0, get_ir(d)}, 64'd0);
        set_ordy(d, 1'b1);
        @(posedge clk); #1;
        set_ordy(d, 1'b0);
        chk({tag, "_rdy_back"}, {63'd0, get_ir(d)}, 64'd1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 3'd0, 64'd0, 64'd0);
            set_ordy(d, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir",    {63'd0, bus0.in_ready},  64'd1);
        chk("rst_ov",    {63'd0, bus0.out_valid}, 64'd0);
        chk("rst_y",     get_y(0),                64'd0);
        chk("rst_state", {62'd0, st0},            64'd0);
        chk("rst_ov64",  {63'd0, bus1.out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32-bit, 8-bit chunks
        run(0, 3'b000, 64'h0000_0005, 64'h0000_0007, 64'd1, 4, "sltu_5_7");
        run(0, 3'b000, 64'h8000_0000, 64'h0000_0001, 64'd0, 1, "sltu_msb");
        run(0, 3'b001, 64'h8000_0000, 64'h0000_0001, 64'd1, 1, "slt_msb");
        run(0, 3'b000, 64'h1234_0000, 64'h1235_0000, 64'd1, 2, "sltu_c1");
        run(0, 3'b000, 64'h0000_1200, 64'h0000_1100, 64'd0, 3, "sltu_c2");
        run(0, 3'b010, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd1, 4, "eq");
        run(0, 3'b011, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0, 4, "ne");
        run(0, 3'b111, 64'hFFFF_FFFF, 64'h0000_0003, 64'h0000_0003, 1, "max");
        run(0, 3'b110, 64'hFFFF_FFFF, 64'h0000_0003, 64'hFFFF_FFFF, 1, "maxu");
        run(0, 3'b101, 64'hFFFF_FFFF, 64'h0000_0003, 64'hFFFF_FFFF, 1, "min");
        run(0, 3'b100, 64'h0000_1234, 64'h0000_1234, 64'h0000_1234, 4, "minu_eq");

        // backpressure, with a request held on in_valid that must not be taken
        accept(0, 3'b000, 64'h0000_0005, 64'h0000_0007);
        wait_done(0, lat);
        chk("bp_lat", 64'(lat), 64'd4);
        drive(0, 1'b1, 3'b010, 64'h0000_0001, 64'h0000_0001);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_y",  get_y(0),                64'd1);
            chk("bp_ov", {63'd0, bus0.out_valid}, 64'd1);
            chk("bp_ir", {63'd0, bus0.in_ready},  64'd0);
        end
        chk("bp_state", {62'd0, st0}, 64'd2);
        drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        set_ordy(0, 1'b0);
        chk("bp_ir_back", {63'd0, bus0.in_ready},  64'd1);
        chk("bp_ov_drop", {63'd0, bus0.out_valid}, 64'd0);

        // reset during the second CMP cycle
        accept(0, 3'b000, 64'h0000_0005, 64'h0000_0007);
        @(posedge clk); #1;
        chk("mid_state", {62'd0, st0}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", {63'd0, bus0.out_valid}, 64'd0);
        chk("mid_rst_y",  get_y(0),                64'd0);
        chk("mid_rst_ir", {63'd0, bus0.in_ready},  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("no_stale_ov", {63'd0, bus0.out_valid}, 64'd0);
        end
        run(0, 3'b000, 64'h0000_0001, 64'h0000_0002, 64'd1, 4, "post_rst_sltu");

        // 64-bit, 16-bit chunks, sign-extended operands
        run(1, 3'b000, 64'h5, 64'h7, 64'd1, 4, "w64_sltu");
        run(1, 3'b001, 64'h8000_0000_0000_0000, 64'h1, 64'd1, 1, "w64_slt");
        run(1, 3'b010, 64'hFFFF_FFFF_DEAD_BEEF, 64'hFFFF_FFFF_DEAD_BEEF, 64'd1, 4, "w64_eq");
        run(1, 3'b011, 64'hFFFF_FFFF_DEAD_BEEF, 64'hFFFF_FFFF_DEAD_BEEF, 64'd0, 4, "w64_ne");
        run(1, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h3, 1, "w64_max");
        run(1, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1, "w64_maxu");
        run(1, 3'b100, 64'h1234, 64'h1234, 64'h1234, 4, "w64_minu");

        // 32-bit, single chunk: every op finishes in one cycle
        run(2, 3'b000, 64'h0000_0005, 64'h0000_0007, 64'd1, 1, "c32_sltu");
        run(2, 3'b010, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd1, 1, "c32_eq");
        run(2, 3'b111, 64'hFFFF_FFFF, 64'h0000_0003, 64'h0000_0003, 1, "c32_max");
        run(2, 3'b100, 64'h0000_1234, 64'h0000_1234, 64'h0000_1234, 1, "c32_minu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
